instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the multicycle CPU: on request from the control path it reads one 32-bit word from memory through a req/ack handshake and holds it in the instruction register. It splits the word into fields and drives `op`/`funct` directly into the controller. A word is loaded only on a completed memory handshake; a pending fetch can be flushed on branch/jump redirect.

## Interface
- `TIMEOUT_CYCLES`, default 255: ack wait limit in cycles when the watchdog is compiled in; range 1..65535.
- `RESET_INSTR`, default 32'h0000_0000: instruction register reset value (decodes as NOP).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  32  fetch address, sampled in the cycle `fetch_req` is accepted.
- `fetch_req`  in  1  start a fetch; accepted only in IDLE.
- `flush`  in  1  abandon the outstanding fetch.
- `mem_req`  out  1  memory read request; held until `mem_ack`.
- `mem_addr`  out  32  latched fetch address; stable while `mem_req` is high.
- `mem_rdata`  in  32  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  read complete; one-cycle pulse.
- `instr`  out  32  instruction register.
- `op`  out  OPECODE  `instr[31:26]`.
- `funct`  out  FUNCT  `instr[5:0]`.
- `rs`, `rt`, `rd`  out  5 each  `instr[25:21]`, `[20:16]`, `[15:11]`.
- `imm`  out  16  `instr[15:0]`.
- `busy`  out  1  high in any state other than IDLE.
- `instr_valid`  out  1  one-cycle pulse after the instruction register loads.
- `fetch_err`  out  1  sticky error flag; cleared on the next accepted `fetch_req`.

## Operation
States: IDLE, WAIT, DRAIN.
- **IDLE**, `fetch_req` with `pc[1:0]==0`: latch `pc` into `mem_addr`, go to WAIT.
- **IDLE**, `fetch_req` with `pc[1:0]!=0`: set `fetch_err`, stay in IDLE. No memory request is issued.
- **WAIT**: `mem_req`=1.
  - `mem_ack` and not `flush`: load `instr` from `mem_rdata`, pulse `instr_valid` the next cycle, go to IDLE.
  - `flush` without `mem_ack`: go to DRAIN. `mem_req` stays high, because the request cannot be withdrawn.
  - `flush` together with `mem_ack`: data is discarded, `instr` is not changed, go to IDLE.
- **DRAIN**: `mem_req`=1. On `mem_ack`, discard data and go to IDLE. `instr` is never written in DRAIN.
- `fetch_req` outside IDLE is ignored, not queued.
- `flush` in IDLE has no effect.
- `instr` holds its value between fetches. Field outputs are combinational slices of `instr`.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=0, `instr`=`RESET_INSTR`, `instr_valid`=0, `busy`=0, `fetch_err`=0.
- `fetch_req` in cycle 0 gives `mem_req`=1 from cycle 1; `mem_req` is decoded from the state register.
- `mem_ack` in cycle k: `instr` is updated at the end of k, `instr_valid`=1 in cycle k+1, `busy`=0 in cycle k+1.
- Minimum fetch latency is 2 cycles, with an ack in cycle 1.
- A new `fetch_req` is accepted in the same cycle as `instr_valid`.
- Reset asserted mid-fetch: return to reset values immediately. A later stray `mem_ack` in IDLE is ignored.

## Configuration
- **`FETCH_WATCHDOG_EN` defined:**
  - A 16-bit counter clears on entry to WAIT or DRAIN and increments every cycle without `mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`: set `fetch_err`, drop `mem_req`, go to IDLE, leave `instr` unchanged.
  - A late ack after the timeout is ignored.
- **Not defined:** no counter; WAIT and DRAIN wait indefinitely. `fetch_err` reports misalignment only.

## Structure
- `lib_cpu` package: `OPECODE`, `FUNCT` (existing), plus the new enum `FETCH_STATE` {IDLE, WAIT, DRAIN} and the reset constant `NOP_INSTR`.
- One sub-module: `fetch_watchdog` (counter, compare, timeout pulse). It is instantiated only under `FETCH_WATCHDOG_EN`.
- Field slicing stays inline.

## Test plan
- **Zero-wait fetch:** `pc`=0x40, memory acks in cycle 1 with 0x8C22_0004 -> `mem_addr`=0x40; `instr_valid` in cycle 2; `op`=6'h23, `rs`=1, `rt`=2, `imm`=4.
- **Wait states:** ack after 5 cycles with 0x0043_0820 -> `mem_req` high cycles 1-6; `busy` high throughout; `op`=0, `funct`=6'h20; a `fetch_req` issued mid-wait is ignored.
- **Flush mid-wait:** flush in cycle 2, ack in cycle 4 with 0xFFFF_FFFF -> `instr` unchanged, no `instr_valid`, IDLE in cycle 5.
- **Misaligned fetch:** `pc`=0x42 -> `mem_req` never rises; `fetch_err`=1 until the next aligned `fetch_req`.
- **Reset mid-fetch:** reset asserted in WAIT, then a stray ack after release -> all outputs at reset values; stray ack ignored.
- **Watchdog (macro defined, `TIMEOUT_CYCLES`=8):** no ack -> `fetch_err` set 8 cycles after WAIT entry, `mem_req`=0, `instr` unchanged.

Source files
------------

// File: rtl/lib_cpu.sv
// Shared CPU types: opcode/funct fields, fetch FSM states, reset instruction.
// Imported by the fetch stage and its watchdog.
package lib_cpu;

   typedef logic [5:0] OPECODE;
   typedef logic [5:0] FUNCT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } FETCH_STATE;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   function automatic logic word_aligned(input logic [31:0] a);
      return a[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Ack-wait watchdog for the fetch stage: counts cycles spent waiting for an ack.
// Ports: clk, reset, clr (restart count), active (waiting), ack, timeout (pulse).
module fetch_watchdog
   import lib_cpu::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic active,
   input  logic ack,
   output logic timeout
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Count holds n-1 in the n-th waiting cycle, so the pulse fires in the
   // TIMEOUT_CYCLES-th cycle without an ack.
   assign timeout = active && !ack && !clr && (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (active && !ack && !timeout) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack word read into the instruction register,
// field split for the controller, flush support. Optional FETCH_WATCHDOG_EN
// adds an ack timeout. Ports: clk, reset, pc, fetch_req, flush, mem_* bus,
// instr and fields, busy, instr_valid, fetch_err.
module instr_fetch
   import lib_cpu::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RESET_INSTR    = NOP_INSTR
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        fetch_req,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] instr,
   output OPECODE      op,
   output FUNCT        funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic        busy,
   output logic        instr_valid,
   output logic        fetch_err
);

   FETCH_STATE  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic        accept;
   logic        wd_clr;
   logic        wd_timeout;

   assign accept = (state_q == IDLE) && fetch_req && word_aligned(pc);

   // Counter restarts on every entry into a waiting state.
   assign wd_clr = accept ||
                   ((state_q == WAIT) && flush && !mem_ack);

`ifdef FETCH_WATCHDOG_EN
   fetch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wd (
      .clk    (clk),
      .reset  (reset),
      .clr    (wd_clr),
      .active (state_q != IDLE),
      .ack    (mem_ack),
      .timeout(wd_timeout)
   );
`else
   logic [16:0] unused_wd;
   assign unused_wd  = {wd_clr, 16'(TIMEOUT_CYCLES)};
   assign wd_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (fetch_req) begin
               if (word_aligned(pc)) begin
                  addr_d  = pc;
                  err_d   = 1'b0;
                  state_d = WAIT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (mem_ack) begin
               // A flush in the ack cycle drops the data.
               if (!flush) begin
                  instr_d = mem_rdata;
                  valid_d = 1'b1;
               end
               state_d = IDLE;
            end else if (flush) begin
               // The request is already on the bus; wait out its ack.
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (wd_timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= RESET_INSTR;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign mem_req     = (state_q != IDLE);
   assign busy        = (state_q != IDLE);
   assign mem_addr    = addr_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;

   assign op    = instr_q[31:26];
   assign rs    = instr_q[25:21];
   assign rt    = instr_q[20:16];
   assign rd    = instr_q[15:11];
   assign imm   = instr_q[15:0];
   assign funct = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected fetched words,
// popped when instr_valid pulses, plus cycle-level handshake checks.
module tb_instr_fetch;
   import lib_cpu::*;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        fetch_req;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] instr;
   OPECODE      op;
   FUNCT        funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic        busy;
   logic        instr_valid;
   logic        fetch_err;

   int total = 0;
   int bad   = 0;
   int nvalid = 0;
   logic [31:0] sb_q[$];

   instr_fetch #(
      .TIMEOUT_CYCLES(8),
      .RESET_INSTR   (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .fetch_req  (fetch_req),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .instr      (instr),
      .op         (op),
      .funct      (funct),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .imm        (imm),
      .busy       (busy),
      .instr_valid(instr_valid),
      .fetch_err  (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         nvalid++;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_valid", instr, 32'hxxxx_xxxx);
         end else begin
            chk("sb_instr", instr, sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      fetch_req = 1'b0;
      flush     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      int nv;
      reset = 1'b1;
      idle_in();
      pc = 32'h0;
      #12;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_err", {31'b0, fetch_err}, 32'd0);
      reset = 1'b0;
      tick();

      // zero-wait fetch
      fetch_req = 1'b1;
      pc = 32'h40;
      tick();
      chk("zw_mem_req", {31'b0, mem_req}, 32'd1);
      chk("zw_mem_addr", mem_addr, 32'h40);
      chk("zw_busy", {31'b0, busy}, 32'd1);
      fetch_req = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'h8C22_0004;
      sb_q.push_back(32'h8C22_0004);
      tick();
      idle_in();
      chk("zw_valid", {31'b0, instr_valid}, 32'd1);
      chk("zw_busy0", {31'b0, busy}, 32'd0);
      chk("zw_op", {26'b0, op}, 32'h23);
      chk("zw_rs", {27'b0, rs}, 32'd1);
      chk("zw_rt", {27'b0, rt}, 32'd2);
      chk("zw_imm", {16'b0, imm}, 32'd4);
      tick();
      chk("zw_valid_pulse", {31'b0, instr_valid}, 32'd0);

      // wait states, with an ignored mid-wait fetch_req
      fetch_req = 1'b1;
      pc = 32'h80;
      tick();
      fetch_req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk("ws_mem_req", {31'b0, mem_req}, 32'd1);
         chk("ws_busy", {31'b0, busy}, 32'd1);
         if (c == 2) begin
            fetch_req = 1'b1;
            pc = 32'h100;
         end else begin
            fetch_req = 1'b0;
         end
         tick();
      end
      chk("ws_mem_req6", {31'b0, mem_req}, 32'd1);
      chk("ws_addr_kept", mem_addr, 32'h80);
      mem_ack = 1'b1;
      mem_rdata = 32'h0043_0820;
      sb_q.push_back(32'h0043_0820);
      tick();
      idle_in();
      chk("ws_valid", {31'b0, instr_valid}, 32'd1);
      chk("ws_mem_req0", {31'b0, mem_req}, 32'd0);
      chk("ws_op", {26'b0, op}, 32'h0);
      chk("ws_funct", {26'b0, funct}, 32'h20);
      chk("ws_rd", {27'b0, rd}, 32'd1);

      // new request in the instr_valid cycle, then flushed mid-wait
      fetch_req = 1'b1;
      pc = 32'hC0;
      tick();
      fetch_req = 1'b0;
      chk("fl_accept_req", {31'b0, mem_req}, 32'd1);
      chk("fl_addr", mem_addr, 32'hC0);
      nv = nvalid;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_drain_req", {31'b0, mem_req}, 32'd1);
      tick();
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      idle_in();
      chk("fl_idle", {31'b0, busy}, 32'd0);
      chk("fl_instr_kept", instr, 32'h0043_0820);
      tick();
      chk("fl_no_valid", nvalid, nv);

      // flush together with ack discards data
      fetch_req = 1'b1;
      pc = 32'hD0;
      tick();
      fetch_req = 1'b0;
      flush = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      idle_in();
      chk("fa_idle", {31'b0, busy}, 32'd0);
      chk("fa_instr_kept", instr, 32'h0043_0820);
      tick();
      chk("fa_no_valid", nvalid, nv);

      // misaligned fetch
      fetch_req = 1'b1;
      pc = 32'h42;
      tick();
      fetch_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("ma_err", {31'b0, fetch_err}, 32'd1);
         chk("ma_no_req", {31'b0, mem_req}, 32'd0);
         tick();
      end
      fetch_req = 1'b1;
      pc = 32'h44;
      tick();
      fetch_req = 1'b0;
      chk("ma_err_clr", {31'b0, fetch_err}, 32'd0);
      chk("ma_req", {31'b0, mem_req}, 32'd1);
      chk("ma_addr", mem_addr, 32'h44);
      mem_ack = 1'b1;
      mem_rdata = 32'h1234_5678;
      sb_q.push_back(32'h1234_5678);
      tick();
      idle_in();
      chk("ma_instr", instr, 32'h1234_5678);
      tick();

`ifdef FETCH_WATCHDOG_EN
      fetch_req = 1'b1;
      pc = 32'h300;
      tick();
      fetch_req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("wd_wait_req", {31'b0, mem_req}, 32'd1);
         chk("wd_err_low", {31'b0, fetch_err}, 32'd0);
         tick();
      end
      chk("wd_err", {31'b0, fetch_err}, 32'd1);
      chk("wd_req_drop", {31'b0, mem_req}, 32'd0);
      chk("wd_instr_kept", instr, 32'h1234_5678);
      nv = nvalid;
      mem_ack = 1'b1;
      mem_rdata = 32'hAAAA_5555;
      tick();
      idle_in();
      tick();
      chk("wd_late_ack", nvalid, nv);
      chk("wd_late_instr", instr, 32'h1234_5678);
`endif

      // reset mid-fetch, then a stray ack
      fetch_req = 1'b1;
      pc = 32'h200;
      tick();
      fetch_req = 1'b0;
      tick();
      chk("rm_waiting", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rm_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rm_mem_addr", mem_addr, 32'h0);
      chk("rm_instr", instr, 32'h0);
      chk("rm_busy", {31'b0, busy}, 32'd0);
      chk("rm_err", {31'b0, fetch_err}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      nv = nvalid;
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      idle_in();
      chk("rm_stray_busy", {31'b0, busy}, 32'd0);
      chk("rm_stray_instr", instr, 32'h0);
      tick();
      chk("rm_stray_valid", nvalid, nv);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
